// File: rtl/calc_1.sv
// calc_1: four independent add/sub/shift calculator ports, 3-cycle latency.
// Optional shifter (commands 5/6) is built only when CALC1_SHIFT_EN is defined.
module calc_1 (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);

  localparam int N = 4;

  logic        rst_n;
  logic        unused_rsv;
  logic [0:3]  cmd  [N];
  logic [0:31] din  [N];
  logic [0:31] dout [N];
  logic [0:1]  rout [N];

  assign rst_n      = reset[1];
  assign unused_rsv = ^reset[2:7];

  assign cmd[0] = req1_cmd_in;
  assign cmd[1] = req2_cmd_in;
  assign cmd[2] = req3_cmd_in;
  assign cmd[3] = req4_cmd_in;
  assign din[0] = req1_data_in;
  assign din[1] = req2_data_in;
  assign din[2] = req3_data_in;
  assign din[3] = req4_data_in;

  assign out_data1 = dout[0];
  assign out_data2 = dout[1];
  assign out_data3 = dout[2];
  assign out_data4 = dout[3];
  assign out_resp1 = rout[0];
  assign out_resp2 = rout[1];
  assign out_resp3 = rout[2];
  assign out_resp4 = rout[3];

  // Result word is {resp[1:0], data[31:0]}; resp 2 always carries data 0.
  function automatic logic [33:0] calc(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] sum;
    logic [33:0] err;
    logic [33:0] res;
    err = {2'd2, 32'd0};
    sum = {1'b0, a} + {1'b0, b};
    res = err;
    case (op)
      4'd1: res = sum[32] ? err : {2'd1, sum[31:0]};
      4'd2: res = (b > a) ? err : {2'd1, a - b};
`ifdef CALC1_SHIFT_EN
      4'd5: res = {2'd1, a << b[4:0]};
      4'd6: res = {2'd1, a >> b[4:0]};
`endif
      default: res = err;
    endcase
    return res;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_port
    logic        wait_op2;
    logic [0:3]  cmd1;
    logic [0:31] op1;
    logic [33:0] r2;
    logic [33:0] r3;
    logic [33:0] res_q;

    assign rout[g] = res_q[33:32];
    assign dout[g] = res_q[31:0];

    // Two-beat capture, compute on op2 beat, then two delay stages to output.
    always_ff @(posedge c_clk) begin
      if (!rst_n) begin
        wait_op2 <= 1'b0;
        cmd1     <= '0;
        op1      <= '0;
        r2       <= '0;
        r3       <= '0;
        res_q    <= '0;
      end else begin
        if (wait_op2) begin
          wait_op2 <= 1'b0;
          r2       <= calc(cmd1, op1, din[g]);
        end else begin
          wait_op2 <= (cmd[g] != 4'd0);
          cmd1     <= cmd[g];
          op1      <= din[g];
          r2       <= '0;
        end
        r3    <= r2;
        res_q <= r3;
      end
    end
  end

endmodule

// File: tb/tb_calc_1.sv
// tb_calc_1: randomized and directed check of calc_1 against a
// transaction-level reference model plus literal pinned results.
module tb_calc_1;

  localparam int MAXC = 4096;
  localparam logic [33:0] ERR = {2'd2, 32'd0};

  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [0:3]  cmd_t  [4];
  logic [0:31] data_t [4];
  logic [0:31] od     [4];
  logic [0:1]  orr    [4];

  always #5 c_clk = ~c_clk;

  calc_1 dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (cmd_t[0]),
    .req1_data_in(data_t[0]),
    .req2_cmd_in (cmd_t[1]),
    .req2_data_in(data_t[1]),
    .req3_cmd_in (cmd_t[2]),
    .req3_data_in(data_t[2]),
    .req4_cmd_in (cmd_t[3]),
    .req4_data_in(data_t[3]),
    .out_data1   (od[0]),
    .out_resp1   (orr[0]),
    .out_data2   (od[1]),
    .out_resp2   (orr[1]),
    .out_data3   (od[2]),
    .out_resp3   (orr[2]),
    .out_data4   (od[3]),
    .out_resp4   (orr[3])
  );

  logic [33:0]     exp_q [4][MAXC];
  logic [33:0]     pin_q [4][MAXC];
  bit              pin_v [4][MAXC];
  int              cyc;
  int              errors;
  int              checks;
  bit              wait_m [4];
  int unsigned     mcmd   [4];
  longint unsigned mop1   [4];
  bit              drv_pend [4];
  logic [0:31]     drv_op2  [4];

  function automatic logic [33:0] ref_calc(
    input int unsigned     c,
    input longint unsigned a,
    input longint unsigned b
  );
    longint unsigned r;
    longint unsigned sh;
    sh = b % 32;
    case (c)
      1: begin
        r = a + b;
        if (r > 64'hFFFF_FFFF) return ERR;
        return {2'd1, r[31:0]};
      end
      2: begin
        if (b > a) return ERR;
        r = a - b;
        return {2'd1, r[31:0]};
      end
`ifdef CALC1_SHIFT_EN
      5: begin
        r = (a << sh) & 64'hFFFF_FFFF;
        return {2'd1, r[31:0]};
      end
      6: begin
        r = a >> sh;
        return {2'd1, r[31:0]};
      end
`endif
      default: return ERR;
    endcase
  endfunction

  task automatic model_edge();
    if (reset[1] == 1'b0) begin
      for (int p = 0; p < 4; p++) begin
        for (int k = 0; k < 4; k++) exp_q[p][cyc+k] = '0;
        wait_m[p] = 1'b0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (wait_m[p]) begin
          exp_q[p][cyc+2] = ref_calc(mcmd[p], mop1[p], data_t[p]);
          wait_m[p] = 1'b0;
        end else if (cmd_t[p] != 4'd0) begin
          wait_m[p] = 1'b1;
          mcmd[p]   = cmd_t[p];
          mop1[p]   = data_t[p];
        end
      end
    end
  endtask

  task automatic compare();
    logic [33:0] got;
    for (int p = 0; p < 4; p++) begin
      got = {orr[p], od[p]};
      checks++;
      if (got !== exp_q[p][cyc]) begin
        errors++;
        $display("FAIL model port%0d cyc%0d got resp=%0d data=%h want resp=%0d data=%h",
                 p + 1, cyc, got[33:32], got[31:0],
                 exp_q[p][cyc][33:32], exp_q[p][cyc][31:0]);
      end
      if (pin_v[p][cyc]) begin
        checks++;
        if (got !== pin_q[p][cyc]) begin
          errors++;
          $display("FAIL pin port%0d cyc%0d got resp=%0d data=%h want resp=%0d data=%h",
                   p + 1, cyc, got[33:32], got[31:0],
                   pin_q[p][cyc][33:32], pin_q[p][cyc][31:0]);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    model_edge();
    @(negedge c_clk);
    compare();
    cyc++;
  endtask

  task automatic set_pin(input int p, input int at, input logic [33:0] v);
    pin_v[p][at] = 1'b1;
    pin_q[p][at] = v;
  endtask

  task automatic issue1(
    input int          p,
    input logic [3:0]  c,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [1:0]  er,
    input logic [31:0] ed
  );
    cmd_t[p]  = c;
    data_t[p] = a;
    set_pin(p, cyc + 3, {er, ed});
    step();
    cmd_t[p]  = 4'd1;
    data_t[p] = b;
    step();
    cmd_t[p]  = 4'd0;
    data_t[p] = '0;
  endtask

  task automatic issue_all(input bit rst_mid);
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [33:0] e [4];
    a[0] = 32'h10;       b[0] = 32'h20; e[0] = {2'd1, 32'h30};
    a[1] = 32'h1000;     b[1] = 32'h2000; e[1] = {2'd1, 32'h3000};
    a[2] = 32'hFFFFFFF0; b[2] = 32'h10; e[2] = ERR;
    a[3] = 32'h7FFFFFFF; b[3] = 32'h1; e[3] = {2'd1, 32'h80000000};
    for (int p = 0; p < 4; p++) begin
      cmd_t[p]  = 4'd1;
      data_t[p] = a[p];
      set_pin(p, cyc + 3, rst_mid ? 34'd0 : e[p]);
    end
    step();
    for (int p = 0; p < 4; p++) begin
      cmd_t[p]  = 4'd2;
      data_t[p] = b[p];
    end
    if (rst_mid) reset = 7'h3F;
    step();
    reset = 7'h7F;
    for (int p = 0; p < 4; p++) begin
      cmd_t[p]  = 4'd0;
      data_t[p] = '0;
    end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom % 4)
      0: return $urandom;
      1: return $urandom % 16;
      2: return 32'hFFFFFFFF - ($urandom % 4);
      default: return $urandom >> ($urandom % 32);
    endcase
  endfunction

  function automatic logic [3:0] pick_cmd();
    case ($urandom % 8)
      0, 1: return 4'd1;
      2, 3: return 4'd2;
      4: return 4'd5;
      5: return 4'd6;
      6: return 4'($urandom);
      default: return 4'd3;
    endcase
  endfunction

  task automatic drive_random();
    if ($urandom % 150 == 0) reset = {1'b0, 6'($urandom)};
    else reset = {1'b1, 6'($urandom)};
    for (int p = 0; p < 4; p++) begin
      if (drv_pend[p]) begin
        cmd_t[p]    = 4'($urandom);
        data_t[p]   = drv_op2[p];
        drv_pend[p] = 1'b0;
      end else if ($urandom % 4 != 0) begin
        cmd_t[p]    = pick_cmd();
        data_t[p]   = rand_word();
        drv_op2[p]  = rand_word();
        drv_pend[p] = (cmd_t[p] != 4'd0);
      end else begin
        cmd_t[p]  = 4'd0;
        data_t[p] = $urandom;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < MAXC; i++) begin
        exp_q[p][i] = '0;
        pin_q[p][i] = '0;
        pin_v[p][i] = 1'b0;
      end
      cmd_t[p]    = '0;
      data_t[p]   = '0;
      wait_m[p]   = 1'b0;
      drv_pend[p] = 1'b0;
      mcmd[p]     = 0;
      mop1[p]     = 0;
      drv_op2[p]  = '0;
    end
    reset = 7'h00;
    for (int p = 0; p < 4; p++) set_pin(p, 0, 34'd0);
    repeat (4) step();
    reset = 7'h7F;

    issue1(0, 4'd1, 32'h00000001, 32'h1FFFFFFF, 2'd1, 32'h20000000);
    issue1(0, 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd2, 32'h0);
    issue1(0, 4'd1, 32'h1FFFFFFF, 32'h1FFFFFFF, 2'd1, 32'h3FFFFFFE);
    issue1(0, 4'd1, 32'h0, 32'h0, 2'd1, 32'h0);
    issue1(0, 4'd1, 32'hFFFFFFFE, 32'h1, 2'd1, 32'hFFFFFFFF);
    issue1(0, 4'd2, 32'h0F, 32'h01, 2'd1, 32'h0E);
    issue1(0, 4'd2, 32'h01, 32'h0F, 2'd2, 32'h0);
    issue1(0, 4'd2, 32'h5, 32'h5, 2'd1, 32'h0);
    issue1(0, 4'd3, 32'h1, 32'h0, 2'd2, 32'h0);
    issue1(0, 4'd4, 32'h1, 32'h0, 2'd2, 32'h0);
`ifdef CALC1_SHIFT_EN
    issue1(0, 4'd5, 32'h1, 32'h4, 2'd1, 32'h10);
    issue1(0, 4'd6, 32'h80000000, 32'd31, 2'd1, 32'h1);
    issue1(0, 4'd5, 32'hFFFFFFFF, 32'h20, 2'd1, 32'hFFFFFFFF);
`else
    issue1(0, 4'd5, 32'h1, 32'h4, 2'd2, 32'h0);
    issue1(0, 4'd6, 32'h80000000, 32'd31, 2'd2, 32'h0);
`endif
    issue1(2, 4'd2, 32'h100, 32'hFF, 2'd1, 32'h1);
    repeat (4) step();
    issue_all(1'b0);
    repeat (3) step();
    issue_all(1'b1);
    repeat (4) step();

    while (cyc < MAXC - 8) begin
      drive_random();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
